// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: instruction layout, opcodes and FSM encoding.
package mem_access_stage_pkg;
  localparam int INSTR_W = 20;
  localparam int OPC_HI  = 19;
  localparam int OPC_LO  = 16;

  localparam logic [3:0] OP_LOAD   = 4'b1011;
  localparam logic [3:0] OP_STORE  = 4'b1100;
  localparam logic [3:0] OP_COPYIN = 4'b1111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_mem_op_decode.sv
// Opcode classifier shared with the MEM control path so both use identical opcode constants.
module mem_op_decode
  import mem_access_stage_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_copyin_o
);
  assign is_load_o   = (opcode_i == OP_LOAD);
  assign is_store_o  = (opcode_i == OP_STORE);
  assign is_copyin_o = (opcode_i == OP_COPYIN);
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: pass-through/COPY INPUT in one cycle, LOAD/STORE via a req/ack
// transaction with a bounded wait; stalls upstream while a transaction is outstanding.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic [INSTR_W-1:0] ex_instruction,
  input  logic [DATA_W-1:0]  ex_alu_result,
  input  logic [DATA_W-1:0]  ex_store_data,
  input  logic [DATA_W-1:0]  io_in,
  mem_access_stage_if.master dmem,
  output logic               mem_stall,
  output logic               wb_valid,
  output logic [INSTR_W-1:0] wb_instruction,
  output logic [DATA_W-1:0]  wb_data,
  output logic               mem_error
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               wb_valid_q, wb_valid_d;
  logic [INSTR_W-1:0] wb_instr_q, wb_instr_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               err_q, err_d;

  logic is_load_s, is_store_s, is_copyin_s;

  mem_op_decode u_decode (
    .opcode_i    (get_opcode(ex_instruction)),
    .is_load_o   (is_load_s),
    .is_store_o  (is_store_s),
    .is_copyin_o (is_copyin_s)
  );

  // Next-state logic for the IDLE/BUSY controller and the MEM/WB result.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    instr_d    = instr_q;
    wb_valid_d = wb_valid_q;
    wb_instr_d = wb_instr_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!ex_valid) begin
          wb_valid_d = 1'b0;
        end else if (is_load_s || is_store_s) begin
          instr_d    = ex_instruction;
          addr_d     = ex_alu_result[ADDR_W-1:0];
          wdata_d    = ex_store_data;
          we_d       = is_store_s;
          req_d      = 1'b1;
          cnt_d      = {CNT_W{1'b0}};
          wb_valid_d = 1'b0;
          state_d    = ST_BUSY;
        end else begin
          wb_valid_d = 1'b1;
          wb_instr_d = ex_instruction;
          wb_data_d  = is_copyin_s ? io_in : ex_alu_result;
        end
      end
      ST_BUSY: begin
        // An ack in the timeout cycle still completes normally.
        if (dmem.dmem_ack) begin
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_instr_d = instr_q;
          wb_data_d  = we_q ? DATA_W'(addr_q) : dmem.dmem_rdata;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          req_d      = 1'b0;
          err_d      = 1'b1;
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          wb_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        req_d      = 1'b0;
        wb_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      instr_q    <= {INSTR_W{1'b0}};
      wb_valid_q <= 1'b0;
      wb_instr_q <= {INSTR_W{1'b0}};
      wb_data_q  <= {DATA_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      instr_q    <= instr_d;
      wb_valid_q <= wb_valid_d;
      wb_instr_q <= wb_instr_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign mem_stall       = (state_q == ST_BUSY) && !dmem.dmem_ack;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign wb_valid        = wb_valid_q;
  assign wb_instruction  = wb_instr_q;
  assign wb_data         = wb_data_q;
  assign mem_error       = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage with a transaction-level reference model.
module tb_mem_access_stage;
  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [19:0] ex_instruction = 20'h0;
  logic [15:0] ex_alu_result = 16'h0;
  logic [15:0] ex_store_data = 16'h0;
  logic [15:0] io_in = 16'h0;
  logic        mem_stall, wb_valid, mem_error;
  logic [19:0] wb_instruction;
  logic [15:0] wb_data;

  int checks = 0;
  int failures = 0;

  mem_access_stage_if #(.DATA_W(16), .ADDR_W(8)) dmem_if ();

  mem_access_stage #(.DATA_W(16), .ADDR_W(8), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_instruction (ex_instruction),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .io_in          (io_in),
    .dmem           (dmem_if),
    .mem_stall      (mem_stall),
    .wb_valid       (wb_valid),
    .wb_instruction (wb_instruction),
    .wb_data        (wb_data),
    .mem_error      (mem_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single-cycle op: pass-through or COPY INPUT. Result expected one edge later.
  task automatic test_passthrough(input logic [3:0] op, input logic [15:0] low,
                                  input logic [15:0] alu, input logic [15:0] io);
    logic [15:0] exp_data;
    exp_data = (op == 4'b1111) ? io : alu;
    ex_valid = 1'b1; ex_instruction = {op, low}; ex_alu_result = alu; io_in = io;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_instruction !== {op, low} || wb_data !== exp_data) begin
      failures++;
      $display("FAIL pass op=%h: got v=%b i=%h d=%h exp v=1 i=%h d=%h",
               op, wb_valid, wb_instruction, wb_data, {op, low}, exp_data);
    end
    checks++;
    if (dmem_if.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL pass_noreq op=%h: got req=%b stall=%b exp 0 0", op, dmem_if.dmem_req, mem_stall);
    end
    ex_valid = 1'b0;
  endtask

  // LOAD/STORE transaction; ack arrives in BUSY cycle index ack_at (>= TIMEOUT means never).
  task automatic run_mem_op(input logic is_store, input logic [15:0] low, input logic [15:0] alu,
                            input logic [15:0] sdata, input logic [15:0] rdata, input int ack_at);
    logic [19:0] instr;
    logic [15:0] exp_data;
    instr = {(is_store ? 4'b1100 : 4'b1011), low};
    exp_data = is_store ? {8'h00, alu[7:0]} : rdata;
    ex_valid = 1'b1; ex_instruction = instr; ex_alu_result = alu; ex_store_data = sdata;
    tick();
    for (int k = 0; k <= TIMEOUT; k++) begin
      if (k == TIMEOUT) begin
        checks++;
        if (dmem_if.dmem_req !== 1'b0 || mem_error !== 1'b1 || wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
          failures++;
          $display("FAIL timeout: got req=%b err=%b wbv=%b stall=%b exp 0 1 0 0",
                   dmem_if.dmem_req, mem_error, wb_valid, mem_stall);
        end
        ex_valid = 1'b0;
        break;
      end else if (k == ack_at) begin
        dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = rdata;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
          failures++;
          $display("FAIL stall_on_ack: got %b exp 0", mem_stall);
        end
        tick();
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = $urandom;
        checks++;
        if (wb_valid !== 1'b1 || wb_instruction !== instr || wb_data !== exp_data || dmem_if.dmem_req !== 1'b0) begin
          failures++;
          $display("FAIL complete st=%b: got v=%b i=%h d=%h req=%b exp v=1 i=%h d=%h req=0",
                   is_store, wb_valid, wb_instruction, wb_data, dmem_if.dmem_req, instr, exp_data);
        end
        checks++;
        if (mem_error !== 1'b0 || mem_stall !== 1'b0) begin
          failures++;
          $display("FAIL complete_err: got err=%b stall=%b exp 0 0", mem_error, mem_stall);
        end
        ex_valid = 1'b0;
        break;
      end else begin
        checks++;
        if (dmem_if.dmem_req !== 1'b1 || dmem_if.dmem_we !== is_store || dmem_if.dmem_addr !== alu[7:0] ||
            dmem_if.dmem_wdata !== sdata || mem_stall !== 1'b1 || wb_valid !== 1'b0) begin
          failures++;
          $display("FAIL busy k=%0d: got req=%b we=%b a=%h wd=%h stall=%b wbv=%b exp 1 %b %h %h 1 0",
                   k, dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata,
                   mem_stall, wb_valid, is_store, alu[7:0], sdata);
        end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_valid = 1'b1; ex_instruction = 20'h1ABCD; ex_alu_result = 16'h1234;
    tick(); tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_instruction !== 20'h0 || wb_data !== 16'h0 || mem_error !== 1'b0 ||
        dmem_if.dmem_req !== 1'b0 || dmem_if.dmem_we !== 1'b0 || dmem_if.dmem_addr !== 8'h0 ||
        dmem_if.dmem_wdata !== 16'h0 || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got wbv=%b wbi=%h wbd=%h err=%b req=%b we=%b a=%h wd=%h stall=%b exp all 0",
               wb_valid, wb_instruction, wb_data, mem_error, dmem_if.dmem_req, dmem_if.dmem_we,
               dmem_if.dmem_addr, dmem_if.dmem_wdata, mem_stall);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h1234 || wb_instruction !== 20'h1ABCD || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_first: got v=%b d=%h i=%h stall=%b exp 1 1234 1abcd 0",
               wb_valid, wb_data, wb_instruction, mem_stall);
    end
    ex_valid = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL bubble: got wbv=%b exp 0", wb_valid);
    end
  endtask

  task automatic test_directed();
    test_passthrough(4'b1111, 16'h0000, 16'h0001, 16'hBEEF);
    run_mem_op(1'b0, 16'h0001, 16'h0042, 16'h0000, 16'hCAFE, 3);
    run_mem_op(1'b1, 16'h0002, 16'h0010, 16'h5A5A, 16'h0000, 0);
    run_mem_op(1'b0, 16'h0003, 16'h0077, 16'h0000, 16'h1357, TIMEOUT - 1);
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: run_mem_op(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 5));
        1: run_mem_op(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 5));
        2: test_passthrough(4'b1111, 16'($urandom), 16'($urandom), 16'($urandom));
        default: begin
          op = 4'($urandom);
          while (op == 4'b1011 || op == 4'b1100 || op == 4'b1111) op = 4'($urandom);
          test_passthrough(op, 16'($urandom), 16'($urandom), 16'($urandom));
        end
      endcase
      if ($urandom_range(0, 2) == 0) tick();
    end
  endtask

  task automatic test_idle_ack();
    dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 16'hDEAD;
    tick();
    dmem_if.dmem_ack = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || dmem_if.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack: got wbv=%b req=%b stall=%b exp 0 0 0", wb_valid, dmem_if.dmem_req, mem_stall);
    end
  endtask

  task automatic test_timeout();
    run_mem_op(1'b0, 16'h0004, 16'h0099, 16'h0000, 16'h0000, 1000);
    test_idle_ack();
    checks++;
    if (mem_error !== 1'b1) begin
      failures++;
      $display("FAIL error_sticky: got %b exp 1", mem_error);
    end
    test_passthrough(4'b0010, 16'h0055, 16'h4321, 16'h0000);
    checks++;
    if (mem_error !== 1'b1) begin
      failures++;
      $display("FAIL error_sticky2: got %b exp 1", mem_error);
    end
  endtask

  task automatic test_reset_busy();
    reset = 1'b1; tick(); reset = 1'b0;
    ex_valid = 1'b1; ex_instruction = 20'hB0001; ex_alu_result = 16'h0033;
    tick(); tick();
    checks++;
    if (dmem_if.dmem_req !== 1'b1 || mem_error !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_busy: got req=%b err=%b exp 1 0", dmem_if.dmem_req, mem_error);
    end
    reset = 1'b1; ex_valid = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if (dmem_if.dmem_req !== 1'b0 || wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got req=%b wbv=%b stall=%b exp 0 0 0", dmem_if.dmem_req, wb_valid, mem_stall);
    end
    test_idle_ack();
  endtask

  initial begin
    dmem_if.dmem_ack = 1'b0;
    dmem_if.dmem_rdata = 16'h0;
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the pipelined processor, sitting between the EX/MEM latch and the WB stage.
- Classifies the 20-bit instruction opcode in bits [19:16], runs LOAD/STORE transactions on the data memory with a req/ack handshake, and substitutes io_in for COPY INPUT.
- Stalls upstream while a memory transaction is outstanding, then presents the MEM/WB result.

Parameters:
- DATA_W, 16, data/ALU word width.
- ADDR_W, 8, data memory address width; address = ex_alu_result[ADDR_W-1:0].
- MEM_TIMEOUT, 15, maximum BUSY cycles without ack before abort (≥1).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  EX/MEM latch holds a valid instruction.
- ex_instruction  in  20  instruction; opcode = [19:16].
- ex_alu_result  in  DATA_W  ALU result / memory address.
- ex_store_data  in  DATA_W  STORE write data.
- io_in  in  DATA_W  external input value for COPY INPUT.
- mem_stall  out  1  hold EX/MEM latch and earlier stages.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write (STORE), 0 = read (LOAD).
- dmem_addr  out  ADDR_W  memory address.
- dmem_wdata  out  DATA_W  write data.
- dmem_ack  in  1  memory completion, one-cycle pulse.
- dmem_rdata  in  DATA_W  read data, valid with ack.
- wb_valid  out  1  MEM/WB entry valid.
- wb_instruction  out  20  instruction passed to WB.
- wb_data  out  DATA_W  result passed to WB.
- mem_error  out  1  sticky timeout flag.

Behaviour:
- Opcodes: OP_LOAD=4'b1011, OP_STORE=4'b1100, OP_COPYIN=4'b1111. Everything else is pass-through.
- Reset (synchronous, active-high): state=IDLE, all registered outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_instruction, wb_data, mem_error), timeout counter 0.
- Reset mid-transaction: drops dmem_req on the next edge; a late ack is ignored.
- FSM states IDLE and BUSY.
- IDLE, ex_valid=0: wb_valid<=0.
- IDLE, ex_valid=1, pass-through opcode: 1-cycle latency.
  - wb_valid<=1, wb_instruction<=ex_instruction.
  - wb_data<=ex_alu_result, or io_in for OP_COPYIN.
- IDLE, ex_valid=1, LOAD/STORE: accept the instruction.
  - Latch instruction, address, wdata and we (we=1 only for STORE).
  - dmem_req<=1; go to BUSY; counter<=0; wb_valid<=0.
- BUSY:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata stay constant until ack.
  - counter increments each cycle without ack.
  - wb_valid<=0 each cycle without ack.
- BUSY with ack:
  - dmem_req<=0; go to IDLE; wb_valid<=1; wb_instruction<=latched instruction.
  - wb_data<=dmem_rdata (LOAD) or latched address zero-extended to DATA_W (STORE).
- BUSY, counter==MEM_TIMEOUT-1 and no ack: abort.
  - dmem_req<=0, mem_error<=1 (sticky until reset), wb_valid<=0, go to IDLE.
  - ack in the same cycle as the timeout: ack wins, no error.
- mem_stall = (state==BUSY) && !dmem_ack, combinational.
  - Upstream advances on the ack edge.
  - Accept edge N, ack seen in cycle M → wb_valid high in cycle M+1.
  - Next instruction is accepted in cycle M+1.
- dmem_ack while IDLE is ignored.
- Back-to-back memory ops: the second is accepted in the first IDLE cycle; dmem_req is low for at least one cycle between requests.
- No flush input; bubbles arrive as ex_valid=0.

Decomposition:
- Shared package:
  - opcode constants OP_LOAD, OP_STORE, OP_COPYIN;
  - field positions OPC_HI=19, OPC_LO=16;
  - state encoding IDLE/BUSY;
  - INSTR_W=20.
- One sub-module, mem_op_decode: combinational opcode → is_load, is_store, is_copyin. It uses the same package constants as the MEM control decoder, so the two cannot diverge.

Test Plan:
- Reset with ex_valid=1, opcode 4'b0001 → after reset deasserts, all outputs 0. Next cycle: wb_valid=1, wb_data=ex_alu_result (e.g. 16'h1234), mem_stall=0.
- OP_COPYIN, io_in=16'hBEEF, ex_alu_result=16'h0001 → one cycle later wb_valid=1, wb_data=16'hBEEF, dmem_req never asserted.
- OP_LOAD, ex_alu_result=16'h0042 → dmem_req=1, dmem_we=0, dmem_addr=8'h42 held.
  - Ack after 3 cycles with rdata=16'hCAFE; mem_stall high until the ack cycle.
  - Next cycle: wb_valid=1, wb_data=16'hCAFE, dmem_req=0.
- OP_STORE, addr 8'h10, store_data 16'h5A5A → dmem_we=1, dmem_wdata=16'h5A5A. Immediate ack in the first BUSY cycle → wb_valid next cycle.
  - Followed by a LOAD: dmem_req deasserted for at least 1 cycle between the two requests.
- LOAD with no ack → after MEM_TIMEOUT=15 BUSY cycles: dmem_req=0, mem_error=1, wb_valid=0, state IDLE.
  - A later ack is ignored; mem_error stays 1 until reset.
- Ack coincident with the 15th BUSY cycle → normal completion, mem_error=0.
- Assert reset during BUSY → dmem_req=0 next cycle, no wb_valid pulse.
